// File: rtl/lab4_logic_bank.sv
// lab4_logic_bank: three fixed Boolean functions with registered outputs
// and a built-in 16-pattern sweep engine that counts the ones per output.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid, a..d     direct-mode sample strobe and inputs (a = MSB)
//   sweep_start        begin exhaustive sweep (accepted only when idle)
//   y1, y2, y3         registered f1(A,B,C), f2(A,B,C), f3(A,B,C,D)
//   out_valid          y1..y3 updated this cycle
//   sweep_active       sweep in progress
//   sweep_idx          pattern {A,B,C,D} behind current y during sweep
//   sweep_done         one-cycle pulse alongside the pattern-15 result
//   ones1..ones3       count of ones per output over the last sweep
module lab4_logic_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       sweep_start,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       out_valid,
  output logic       sweep_active,
  output logic [3:0] sweep_idx,
  output logic       sweep_done,
  output logic [4:0] ones1,
  output logic [4:0] ones2,
  output logic [4:0] ones3
);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       y1_q, y1_d;
  logic       y2_q, y2_d;
  logic       y3_q, y3_d;
  logic       ov_q, ov_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic [4:0] ones1_q, ones1_d;
  logic [4:0] ones2_q, ones2_d;
  logic [4:0] ones3_q, ones3_d;

  // Pattern is {A,B,C,D}; f1/f2 ignore D.
  function automatic logic f1(input logic [3:0] p);
    f1 = (~p[3] & ~p[1]) | (p[3] & p[2]);
  endfunction

  function automatic logic f2(input logic [3:0] p);
    f2 = p[3] ^ p[2] ^ p[1];
  endfunction

  function automatic logic f3(input logic [3:0] p);
    f3 = (p[3] & p[2]) | (p[1] & p[0]);
  endfunction

  logic [3:0] pin;
  logic       s1, s2, s3;

  assign pin = {a, b, c, d};
  assign s1  = f1(cnt_q);
  assign s2  = f2(cnt_q);
  assign s3  = f3(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    ov_d    = 1'b0;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ones1_d = ones1_q;
    ones2_d = ones2_q;
    ones3_d = ones3_q;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = 4'd0;
          ones1_d = 5'd0;
          ones2_d = 5'd0;
          ones3_d = 5'd0;
        end else if (in_valid) begin
          y1_d = f1(pin);
          y2_d = f2(pin);
          y3_d = f3(pin);
          ov_d = 1'b1;
        end
      end
      S_SWEEP: begin
        y1_d    = s1;
        y2_d    = s2;
        y3_d    = s3;
        ov_d    = 1'b1;
        idx_d   = cnt_q;
        ones1_d = ones1_q + {4'd0, s1};
        ones2_d = ones2_q + {4'd0, s2};
        ones3_d = ones3_q + {4'd0, s3};
        cnt_d   = cnt_q + 4'd1;
        // Pattern 15 is the last; the counter wraps to 0 here.
        if (cnt_q == 4'd15) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      y1_q    <= 1'b0;
      y2_q    <= 1'b0;
      y3_q    <= 1'b0;
      ov_q    <= 1'b0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      ones1_q <= 5'd0;
      ones2_q <= 5'd0;
      ones3_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ones1_q <= ones1_d;
      ones2_q <= ones2_d;
      ones3_q <= ones3_d;
    end
  end

  assign y1           = y1_q;
  assign y2           = y2_q;
  assign y3           = y3_q;
  assign out_valid    = ov_q;
  assign sweep_active = (state_q == S_SWEEP);
  assign sweep_idx    = idx_q;
  assign sweep_done   = done_q;
  assign ones1        = ones1_q;
  assign ones2        = ones2_q;
  assign ones3        = ones3_q;

endmodule

// File: tb/tb_lab4_logic_bank.sv
// Bench for lab4_logic_bank: directed steps plus random traffic,
// each cycle compared with a minterm-table reference model.
module tb_lab4_logic_bank;

  logic       clk = 1'b0;
  logic       rst, in_valid, a, b, c, d, sweep_start;
  logic       y1, y2, y3, out_valid, sweep_active, sweep_done;
  logic [3:0] sweep_idx;
  logic [4:0] ones1, ones2, ones3;

  int tests = 0;
  int fails = 0;

  lab4_logic_bank dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .sweep_start(sweep_start),
    .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid),
    .sweep_active(sweep_active),
    .sweep_idx(sweep_idx),
    .sweep_done(sweep_done),
    .ones1(ones1), .ones2(ones2), .ones3(ones3)
  );

  always #5 clk = ~clk;

  // Reference model state (plain ints, minterm lists).
  int m_y1, m_y2, m_y3, m_ov, m_act, m_idx, m_done;
  int m_o1, m_o2, m_o3, m_cnt;

  function automatic int rf1(input int p);
    int abc;
    abc = p / 2;
    return (abc inside {0, 2, 6, 7}) ? 1 : 0;
  endfunction

  function automatic int rf2(input int p);
    int abc;
    abc = p / 2;
    return (abc inside {1, 2, 4, 7}) ? 1 : 0;
  endfunction

  function automatic int rf3(input int p);
    return (p inside {3, 7, 11, 12, 13, 14, 15}) ? 1 : 0;
  endfunction

  task automatic model(input int r, input int iv,
                       input int p, input int ss);
    if (r != 0) begin
      m_y1 = 0; m_y2 = 0; m_y3 = 0; m_ov = 0;
      m_act = 0; m_idx = 0; m_done = 0;
      m_o1 = 0; m_o2 = 0; m_o3 = 0; m_cnt = 0;
    end else if (m_act != 0) begin
      m_y1 = rf1(m_cnt); m_y2 = rf2(m_cnt); m_y3 = rf3(m_cnt);
      m_o1 += m_y1; m_o2 += m_y2; m_o3 += m_y3;
      m_idx = m_cnt; m_ov = 1;
      m_done = (m_cnt == 15) ? 1 : 0;
      if (m_cnt == 15) m_act = 0;
      m_cnt = (m_cnt + 1) % 16;
    end else if (ss != 0) begin
      m_act = 1; m_cnt = 0; m_ov = 0; m_done = 0;
      m_o1 = 0; m_o2 = 0; m_o3 = 0;
    end else begin
      m_done = 0;
      m_ov = iv;
      if (iv != 0) begin
        m_y1 = rf1(p); m_y2 = rf2(p); m_y3 = rf3(p);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("y1", int'(y1), m_y1);
    chk("y2", int'(y2), m_y2);
    chk("y3", int'(y3), m_y3);
    chk("out_valid", int'(out_valid), m_ov);
    chk("sweep_active", int'(sweep_active), m_act);
    chk("sweep_idx", int'(sweep_idx), m_idx);
    chk("sweep_done", int'(sweep_done), m_done);
    chk("ones1", int'(ones1), m_o1);
    chk("ones2", int'(ones2), m_o2);
    chk("ones3", int'(ones3), m_o3);
  endtask

  task automatic step(input int r, input int iv,
                      input int p, input int ss);
    @(negedge clk);
    rst = r[0];
    in_valid = iv[0];
    {a, b, c, d} = p[3:0];
    sweep_start = ss[0];
    @(posedge clk);
    model(r, iv, p, ss);
    #1;
    chk_all();
  endtask

  logic [7:0] y1tab;
  logic [7:0] y2tab;
  int         guard;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sweep_start = 1'b0;
    {a, b, c, d} = 4'd0;
    y1tab = 8'b1100_0101;
    y2tab = 8'b1001_0110;

    // Reset, then abcd=0000.
    step(1, 0, 0, 0);
    chk("rst_y1", int'(y1), 0);
    step(0, 1, 0, 0);
    chk("first_y1", int'(y1), 1);
    chk("first_ov", int'(out_valid), 1);

    // All abc with d=0.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, i * 2, 0);
      chk("tab_y1", int'(y1), int'(y1tab[i]));
      chk("tab_y2", int'(y2), int'(y2tab[i]));
      chk("tab_y3", int'(y3), (i >= 6) ? 1 : 0);
    end

    step(0, 1, 4'b0011, 0);
    chk("cd_y3", int'(y3), 1);
    step(0, 1, 4'b1001, 0);
    chk("ad_y3", int'(y3), 0);
    step(0, 0, 4'b1111, 0);
    chk("hold_ov", int'(out_valid), 0);
    chk("hold_y3", int'(y3), 0);

    // Single-pulse sweep.
    step(0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0);
      chk("sw_idx", int'(sweep_idx), k);
      chk("sw_ov", int'(out_valid), 1);
      chk("sw_done", int'(sweep_done), (k == 15) ? 1 : 0);
    end
    chk("sw_ones1", int'(ones1), 8);
    chk("sw_ones2", int'(ones2), 8);
    chk("sw_ones3", int'(ones3), 7);
    step(0, 0, 0, 0);
    chk("sw_after", int'(sweep_active), 0);

    // Sweep with in_valid and sweep_start held high.
    for (int k = 0; k < 17; k++)
      step(0, 1, $urandom_range(15), 1);
    chk("hold_ones1", int'(ones1), 8);
    chk("hold_ones2", int'(ones2), 8);
    chk("hold_ones3", int'(ones3), 7);
    chk("hold_done", int'(sweep_done), 1);
    step(0, 1, $urandom_range(15), 1);
    chk("restart", int'(sweep_active), 1);
    for (int k = 0; k < 16; k++)
      step(0, 0, 0, 0);

    // Reset in the middle of a sweep.
    step(0, 0, 0, 1);
    guard = 0;
    while (sweep_idx != 4'd6 && guard < 20) begin
      step(0, 0, 0, 0);
      guard++;
    end
    chk("reach_idx6", int'(sweep_idx), 6);
    step(1, 1, 4'hF, 1);
    chk("abort_act", int'(sweep_active), 0);
    chk("abort_ones3", int'(ones3), 0);
    step(0, 0, 0, 1);
    for (int k = 0; k < 16; k++)
      step(0, 0, 0, 0);
    chk("re_ones1", int'(ones1), 8);
    chk("re_ones2", int'(ones2), 8);
    chk("re_ones3", int'(ones3), 7);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(59) == 0) ? 1 : 0,
           int'($urandom_range(1)),
           int'($urandom_range(15)),
           ($urandom_range(14) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
